mfp_vga_scan_ctrl: RTL and testbench

VGA scan controller that sequences the read port of the 12-bit video RAM (VRAM), 640x480 pixels. It generates 640x480@60 Hz raster timing from the system clock, walks the VRAM read address in raster order, and aligns the returned pixel data with the horizontal/vertical sync outputs. It sits between the VRAM read port and the board VGA connector, and provides a frame interrupt for the MIPSfpga core.

---
 rtl/mfp_vga_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mfp_vga_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mfp_vga_scan_ctrl.sv
// VGA raster scan controller: walks the VRAM read port in raster order and emits
// pixel-aligned colour/sync. Optional sticky frame interrupt under MFP_VGA_FRAME_IRQ_EN.
module mfp_vga_scan_ctrl #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        en,
    output logic [18:0] IO_VGA_ADDR,
    input  logic [11:0] IO_VGA_DATA,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        vblank,
    output logic        frame_irq,
    input  logic        irq_ack
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned D_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [D_W-1:0] D_LAST = D_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_IRQ  = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (CLK_DIV < RAM_LATENCY + 1) begin : g_div_check
        $error("CLK_DIV must be greater than RAM_LATENCY");
    end

    logic [D_W-1:0] div_q, div_d;
    logic [H_W-1:0] h_q, h_d, h_nxt;
    logic [V_W-1:0] v_q, v_d, v_nxt;
    logic [18:0]    addr_q, addr_d;
    logic [11:0]    rgb_q, rgb_d;
    logic           hs_q, hs_d, vs_q, vs_d, vblank_q, vblank_d;
    logic           tick, h_wrap, v_wrap, pix_act;

    always_comb begin
        tick    = (div_q == D_LAST);
        h_wrap  = (h_q == H_LAST);
        v_wrap  = (v_q == V_LAST);
        h_nxt   = h_wrap ? '0 : h_q + 1'b1;
        v_nxt   = h_wrap ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
        pix_act = (h_q < H_ACT) && (v_q < V_ACT);

        div_d    = div_q;
        h_d      = h_q;
        v_d      = v_q;
        addr_d   = addr_q;
        rgb_d    = rgb_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        vblank_d = vblank_q;

        if (!en) begin
            div_d    = '0;
            h_d      = '0;
            v_d      = '0;
            addr_d   = '0;
            rgb_d    = '0;
            hs_d     = 1'b1;
            vs_d     = 1'b1;
            vblank_d = 1'b0;
        end else if (tick) begin
            div_d = '0;
            h_d   = h_nxt;
            v_d   = v_nxt;
            // Address tracks the pixel being entered, so it holds the last active
            // value through blanking and only clears on the frame wrap.
            if (h_wrap && v_wrap)
                addr_d = '0;
            else if ((h_nxt < H_ACT) && (v_nxt < V_ACT))
                addr_d = addr_q + 19'd1;
            // Outputs describe the pixel just finished, whose data is now valid.
            rgb_d    = pix_act ? IO_VGA_DATA : '0;
            hs_d     = !((h_q >= HS_BEG) && (h_q <= HS_END));
            vs_d     = !((v_q >= VS_BEG) && (v_q <= VS_END));
            vblank_d = (v_q >= V_ACT);
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            addr_q   <= '0;
            rgb_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            vblank_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            addr_q   <= addr_d;
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            vblank_q <= vblank_d;
        end
    end

`ifdef MFP_VGA_FRAME_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (irq_ack)
            irq_d = 1'b0;
        if (tick && h_wrap && (v_q == V_IRQ))
            irq_d = 1'b1;
        if (!en)
            irq_d = 1'b0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)
            irq_q <= 1'b0;
        else
            irq_q <= irq_d;
    end

    assign frame_irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign frame_irq      = 1'b0;
`endif

    assign IO_VGA_ADDR = addr_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign vblank      = vblank_q;

endmodule

// File: tb/tb_mfp_vga_scan_ctrl.sv
// Bench for mfp_vga_scan_ctrl with a shortened vertical frame (15 lines) and full-width lines.
module tb_mfp_vga_scan_ctrl;

    localparam int HA = 640, HT = 800, HSB = 656, HSE = 751;
    localparam int VA = 8, VT = 15, VSB = 10, VSE = 11;
    localparam int CD = 2;
`ifdef MFP_VGA_FRAME_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, ack;
    logic [18:0] addr;
    logic [11:0] vram_data = '0;
    logic [3:0]  r, g, b;
    logic        hs, vs, vb, irq;
    logic [11:0] rgb;

    assign rgb = {r, g, b};

    always #5 clk = ~clk;

    mfp_vga_scan_ctrl #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(VA), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(CD), .RAM_LATENCY(1)
    ) dut (
        .HCLK(clk), .HRESET(rst), .en(en),
        .IO_VGA_ADDR(addr), .IO_VGA_DATA(vram_data),
        .VGA_R(r), .VGA_G(g), .VGA_B(b),
        .VGA_HS(hs), .VGA_VS(vs), .vblank(vb),
        .frame_irq(irq), .irq_ack(ack)
    );

    // VRAM model: returns the low 12 address bits one cycle later
    always @(posedge clk) vram_data <= addr[11:0];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [18:0] addr;
        logic [11:0] rgb;
        logic        hs, vs, vb, irq;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e, sb_e;
    int   m_cyc = 0, m_pix, m_h, m_v, m_p, m_ph, m_pv;
    logic m_irq = 1'b0;

    // Reference: position derived from elapsed cycles since scan start
    always @(posedge clk) begin
        if (rst || !en) begin
            m_cyc = 0;
            m_irq = 1'b0;
        end else begin
            m_cyc = m_cyc + 1;
            m_pix = m_cyc / CD;
            if (ack) m_irq = 1'b0;
            if (IRQ_ON && (m_cyc % CD == 0) && (m_pix % HT == 0) && ((m_pix / HT) % VT == VA))
                m_irq = 1'b1;
        end
        m_pix = m_cyc / CD;
        m_h = m_pix % HT;
        m_v = (m_pix / HT) % VT;
        if (m_v >= VA) m_e.addr = 19'(VA * HA - 1);
        else if (m_h >= HA) m_e.addr = 19'(m_v * HA + HA - 1);
        else m_e.addr = 19'(m_v * HA + m_h);
        if (m_pix == 0) begin
            m_e.rgb = '0; m_e.hs = 1'b1; m_e.vs = 1'b1; m_e.vb = 1'b0;
        end else begin
            m_p  = m_pix - 1;
            m_ph = m_p % HT;
            m_pv = (m_p / HT) % VT;
            m_e.rgb = (m_ph < HA && m_pv < VA) ? 12'((m_pv * HA + m_ph) % 4096) : 12'h000;
            m_e.hs  = !(m_ph >= HSB && m_ph <= HSE);
            m_e.vs  = !(m_pv >= VSB && m_pv <= VSE);
            m_e.vb  = (m_pv >= VA);
        end
        m_e.irq = m_irq;
        sb_q.push_back(m_e);
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            check("scan", 64'({addr, rgb, hs, vs, vb, irq}), 64'(sb_e));
        end
    end

    int n;
    int hs_f1 = 0, hs_f2 = 0, hs_r1 = 0, vs_f1 = 0, vs_f2 = 0, vs_r1 = 0, vb_r1 = 0, vb_f1 = 0;
    int amax = 0;
    logic hs_p, vs_p, vb_p;

    task automatic tick();
        @(negedge clk);
        n++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", 64'(addr), 64'(0));
        check("rst_rgb", 64'(rgb), 64'(0));
        check("rst_hs", 64'(hs), 64'(1));
        check("rst_vs", 64'(vs), 64'(1));
        check("rst_irq", 64'(irq), 64'(0));
        rst = 1'b0;
        n = 0;
        hs_p = hs; vs_p = vs; vb_p = vb;
        while (n < 40100) begin
            tick();
            if (!hs && hs_p) begin
                if (hs_f1 == 0) hs_f1 = n; else if (hs_f2 == 0) hs_f2 = n;
            end
            if (hs && !hs_p && hs_r1 == 0) hs_r1 = n;
            if (!vs && vs_p) begin
                if (vs_f1 == 0) vs_f1 = n; else if (vs_f2 == 0) vs_f2 = n;
            end
            if (vs && !vs_p && vs_r1 == 0) vs_r1 = n;
            if (vb && !vb_p && vb_r1 == 0) vb_r1 = n;
            if (!vb && vb_p && vb_f1 == 0) vb_f1 = n;
            hs_p = hs; vs_p = vs; vb_p = vb;
            if (int'(addr) > amax) amax = int'(addr);
            case (n)
                2:     check("addr_first", 64'(addr), 64'(1));
                12:    check("rgb_pix5", 64'(rgb), 64'(12'h005));
                1282:  check("rgb_hblank", 64'(rgb), 64'(0));
                1599:  check("addr_eol0", 64'(addr), 64'(639));
                1600:  check("addr_sol1", 64'(addr), 64'(640));
                1608:  check("rgb_l1p3", 64'(rgb), 64'(12'h283));
                12799: check("irq_pre", 64'(irq), 64'(0));
                12800: check("irq_set", 64'(irq), 64'(IRQ_ON));
                12900: begin check("irq_hold", 64'(irq), 64'(IRQ_ON)); ack = 1'b1; end
                12901: begin check("irq_ack", 64'(irq), 64'(0)); ack = 1'b0; end
                23999: check("addr_last", 64'(addr), 64'(VA * HA - 1));
                24000: check("addr_wrap", 64'(addr), 64'(0));
                36799: ack = 1'b1;
                36800: begin check("irq_set_ack", 64'(irq), 64'(IRQ_ON)); ack = 1'b0; end
                36801: check("irq_set_wins", 64'(irq), 64'(IRQ_ON));
                default: ;
            endcase
        end
        check("hs_fall", 64'(hs_f1), 64'(1314));
        check("hs_low", 64'(hs_r1 - hs_f1), 64'(192));
        check("hs_period", 64'(hs_f2 - hs_f1), 64'(1600));
        check("vs_fall", 64'(vs_f1), 64'(16002));
        check("vs_low", 64'(vs_r1 - vs_f1), 64'(3200));
        check("vs_period", 64'(vs_f2 - vs_f1), 64'(24000));
        check("vb_rise", 64'(vb_r1), 64'(12802));
        check("vb_len", 64'(vb_f1 - vb_r1), 64'((VT - VA) * HT * CD));
        check("addr_peak", 64'(amax), 64'(VA * HA - 1));

        // drop enable at pixel (300,5) of the third frame
        while (n < 56600) tick();
        check("pre_drop_rgb", 64'(rgb), 64'(12'hDAB));
        en = 1'b0;
        tick();
        check("en0_rgb", 64'(rgb), 64'(0));
        check("en0_hs", 64'(hs), 64'(1));
        check("en0_vs", 64'(vs), 64'(1));
        check("en0_addr", 64'(addr), 64'(0));
        check("en0_vb", 64'(vb), 64'(0));
        repeat (3) tick();
        en = 1'b1;
        n = 0;
        repeat (2) tick();
        check("en1_addr", 64'(addr), 64'(1));
        repeat (10) tick();
        check("en1_rgb5", 64'(rgb), 64'(12'h005));

        // reset at pixel (700,10): HS and VS both low, in vblank
        while (n < 17400) tick();
        check("pre_rst_hs", 64'(hs), 64'(0));
        check("pre_rst_vs", 64'(vs), 64'(0));
        rst = 1'b1;
        tick();
        check("mrst_hs", 64'(hs), 64'(1));
        check("mrst_vs", 64'(vs), 64'(1));
        check("mrst_addr", 64'(addr), 64'(0));
        check("mrst_vb", 64'(vb), 64'(0));
        check("mrst_irq", 64'(irq), 64'(0));
        rst = 1'b0;
        n = 0;
        repeat (2) tick();
        check("mrst_addr1", 64'(addr), 64'(1));
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
